// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter sharing one UMI host request port between N sources
// through a one-entry output register. Define UMI_ARB_PRIO0_EN for strict priority of requester 0.
module umi_req_arbiter #(
    parameter int N          = 2,
    parameter int CMD_WIDTH  = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [N-1:0]              in_req_valid,
    input  logic [N*CMD_WIDTH-1:0]    in_req_cmd,
    input  logic [N*ADDR_WIDTH-1:0]   in_req_dstaddr,
    input  logic [N*ADDR_WIDTH-1:0]   in_req_srcaddr,
    input  logic [N*DATA_WIDTH-1:0]   in_req_data,
    output logic [N-1:0]              in_req_ready,
    output logic                      out_req_valid,
    output logic [CMD_WIDTH-1:0]      out_req_cmd,
    output logic [ADDR_WIDTH-1:0]     out_req_dstaddr,
    output logic [ADDR_WIDTH-1:0]     out_req_srcaddr,
    output logic [DATA_WIDTH-1:0]     out_req_data,
    output logic [$clog2(N)-1:0]      out_req_id,
    input  logic                      out_req_ready
);
    localparam int IDW = $clog2(N);

    logic [CMD_WIDTH-1:0]  cmd_arr  [N];
    logic [ADDR_WIDTH-1:0] dst_arr  [N];
    logic [ADDR_WIDTH-1:0] src_arr  [N];
    logic [DATA_WIDTH-1:0] data_arr [N];

    logic                  valid_reg;
    logic [CMD_WIDTH-1:0]  cmd_reg;
    logic [ADDR_WIDTH-1:0] dst_reg;
    logic [ADDR_WIDTH-1:0] src_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [IDW-1:0]        id_reg;
    logic [IDW-1:0]        last_reg;

    logic                  load;
    logic                  any_valid;
    logic [IDW-1:0]        win_idx;
    logic                  upd_last;

    // First valid requester after 'last', wrapping modulo N.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        logic           found;
        int             c;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!found && v[c]) begin
                pick  = IDW'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign cmd_arr[gi]      = in_req_cmd[gi*CMD_WIDTH +: CMD_WIDTH];
            assign dst_arr[gi]      = in_req_dstaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign src_arr[gi]      = in_req_srcaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi]     = in_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // Gated by nreset so no handshake can complete while held in reset.
            assign in_req_ready[gi] = nreset && load && any_valid && (win_idx == IDW'(gi));
        end
    endgenerate

    assign any_valid = |in_req_valid;
    assign load      = !valid_reg || out_req_ready;

    always_comb begin
        win_idx  = '0;
        upd_last = 1'b1;
`ifdef UMI_ARB_PRIO0_EN
        // Requester 0 bypasses the rotation and leaves the pointer untouched.
        if (in_req_valid[0]) begin
            win_idx  = '0;
            upd_last = 1'b0;
        end else begin
            win_idx = rr_pick({in_req_valid[N-1:1], 1'b0}, last_reg);
        end
`else
        win_idx = rr_pick(in_req_valid, last_reg);
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_reg <= 1'b0;
            cmd_reg   <= '0;
            dst_reg   <= '0;
            src_reg   <= '0;
            data_reg  <= '0;
            id_reg    <= '0;
            last_reg  <= IDW'(N-1);
        end else if (load) begin
            if (any_valid) begin
                valid_reg <= 1'b1;
                cmd_reg   <= cmd_arr[win_idx];
                dst_reg   <= dst_arr[win_idx];
                src_reg   <= src_arr[win_idx];
                data_reg  <= data_arr[win_idx];
                id_reg    <= win_idx;
                if (upd_last) begin
                    last_reg <= win_idx;
                end
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_req_valid   = valid_reg;
    assign out_req_cmd     = cmd_reg;
    assign out_req_dstaddr = dst_reg;
    assign out_req_srcaddr = src_reg;
    assign out_req_data    = data_reg;
    assign out_req_id      = id_reg;

endmodule
